store_align_buffer: RTL and testbench

//  MEM-stage store path: write-side counterpart of the load extract/extend logic.
//  - Takes byte/half/word stores from the pipeline.
//  - Replicates the data into all byte lanes and builds the 4-bit byte-enable from addr[1:0].
//  - Queues stores in a small in-order buffer.
//  - Issues them to the data-memory port with a req/gnt handshake.
//  - busy lets the hazard unit stall loads while stores are outstanding.

---
 rtl/mem_pkg.sv | 62 ++++++
 rtl/store_fifo.sv | 83 ++++++++
 rtl/store_align_buffer.sv | 132 +++++++++++++
 tb/tb_store_align_buffer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage store path.
//
// Contents:
//   mem_size_e  - access size decoded from the pipeline byte/half flags
//   st_entry_t  - one queued store: word address, lane-replicated data, byte enables
//   BE_*        - byte-enable patterns for a lane-0 access of each size
//   lane_be     - byte enables for a size at a given byte offset
//   lane_wdata  - right-justified data replicated across all byte lanes
//   misaligned  - natural-alignment check (byte accesses are never misaligned)

package mem_pkg;

  // Widest byte address a store entry can carry; the top truncates to its ADDR_W.
  localparam int unsigned ST_ADDR_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } mem_size_e;

  typedef struct packed {
    logic [ST_ADDR_W-1:0] addr;
    logic [31:0]          wdata;
    logic [3:0]           be;
  } st_entry_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'hF;

  function automatic logic [3:0] lane_be(input mem_size_e size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = BE_BYTE << a;
      SZ_HALF: be = BE_HALF << {a[1], 1'b0};
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input mem_size_e size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic misaligned(input mem_size_e size, input logic [1:0] a);
    logic m;
    case (size)
      SZ_HALF: m = a[0];
      SZ_WORD: m = (a != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Generic in-order synchronous FIFO of st_entry_t.
//
// Parameters:
//   DEPTH  number of entries (power of 2, >= 2) so pointers wrap naturally
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset; clears pointers and count
//   push      write wr_entry at the tail (ignored when full)
//   wr_entry  entry to write
//   pop       retire the head entry (ignored when empty)
//   full      count == DEPTH
//   empty     count == 0
//   head      entry at the read pointer (undefined content when empty)

module store_fifo
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  st_entry_t wr_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output st_entry_t head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  st_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed through a valid count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: rtl/store_align_buffer.sv
// MEM-stage store path: lane replication, byte-enable generation, an in-order
// store buffer and a req/gnt issue port toward data memory.
//
// Optional feature macro: STORE_MISALIGN_TRAP_EN
//   defined   - misaligned half/word stores are accepted but dropped, and raise a
//               one-cycle misalign_exc pulse with the address latched in exc_addr
//   undefined - no alignment check; word ignores a[1:0], half ignores a[0];
//               misalign_exc and exc_addr are tied to 0
//
// Parameters:
//   DEPTH   buffer entries (power of 2, >= 2)
//   ADDR_W  byte-address width (<= 32)
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   st_valid/st_ready   store request handshake (st_ready = !full, from state)
//   st_byte, st_half    size select; byte wins, neither means word
//   st_addr, st_data    byte address, right-justified data
//   mem_req/mem_gnt     head-entry issue handshake
//   mem_addr            word-aligned address of the head entry
//   mem_wdata, mem_be   lane-replicated data, byte enables (0 when idle)
//   busy                buffer non-empty
//   misalign_exc        misaligned store trap pulse
//   exc_addr            faulting address, held until the next trap

module store_align_buffer
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic              st_byte,
  input  logic              st_half,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              busy,
  output logic              misalign_exc,
  output logic [ADDR_W-1:0] exc_addr
);

  mem_size_e size;
  st_entry_t wr_entry;
  st_entry_t head;
  logic      accept;
  logic      push;
  logic      pop;
  logic      full;
  logic      empty;

  always_comb begin
    if (st_byte) begin
      size = SZ_BYTE;
    end else if (st_half) begin
      size = SZ_HALF;
    end else begin
      size = SZ_WORD;
    end
  end

  always_comb begin
    wr_entry       = '0;
    wr_entry.addr  = ST_ADDR_W'({st_addr[ADDR_W-1:2], 2'b00});
    wr_entry.wdata = lane_wdata(size, st_data);
    wr_entry.be    = lane_be(size, st_addr[1:0]);
  end

  // st_ready comes straight from the registered count, so a pop in the same
  // cycle never frees a slot early: there is no full-bypass path.
  assign st_ready = !full;
  assign accept   = st_valid && st_ready;
  assign pop      = mem_req && mem_gnt;

`ifdef STORE_MISALIGN_TRAP_EN
  logic              trap;
  logic              exc_q;
  logic [ADDR_W-1:0] exc_addr_q;

  // A trapping store still consumes the handshake so the producer moves on.
  assign trap = accept && misaligned(size, st_addr[1:0]);
  assign push = accept && !trap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      exc_q <= trap;
      if (trap) begin
        exc_addr_q <= st_addr;
      end
    end
  end

  assign misalign_exc = exc_q;
  assign exc_addr     = exc_addr_q;
`else
  assign push         = accept;
  assign misalign_exc = 1'b0;
  assign exc_addr     = '0;
`endif

  store_fifo #(
    .DEPTH(DEPTH)
  ) u_store_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_entry(wr_entry),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  // Everything toward memory comes from FIFO state only, so st_* never reaches
  // mem_* combinationally and the head stays stable until granted.
  assign mem_req   = !empty;
  assign busy      = !empty;
  assign mem_addr  = head.addr[ADDR_W-1:0];
  assign mem_wdata = head.wdata;
  assign mem_be    = empty ? 4'h0 : head.be;

endmodule

// File: tb/tb_store_align_buffer.sv
// Self-checking bench for store_align_buffer (DEPTH=2, ADDR_W=32).
// Expected issues are queued as stores are accepted and compared as mem_req&&mem_gnt
// handshakes are observed. Inputs change 1ns after the rising edge; outputs are
// sampled on the falling edge.

module tb_store_align_buffer;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned ADDR_W = 32;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              st_valid;
  logic              st_ready;
  logic              st_byte;
  logic              st_half;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              busy;
  logic              misalign_exc;
  logic [ADDR_W-1:0] exc_addr;

  int   checks = 0;
  int   errors = 0;
  int   n_issued = 0;
  exp_t sb[$];
  exp_t mon_e;

  store_align_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_byte     (st_byte),
    .st_half     (st_half),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .busy        (busy),
    .misalign_exc(misalign_exc),
    .exc_addr    (exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  // Scoreboard: every handshake must match the oldest outstanding store.
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_gnt) begin
      checks++;
      n_issued++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: addr=%h wdata=%h be=%b with no store outstanding",
                 mem_addr, mem_wdata, mem_be);
      end else begin
        mon_e = sb.pop_front();
        if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.wdata || mem_be !== mon_e.be) begin
          errors++;
          $display("FAIL issue_order: got addr=%h wdata=%h be=%b, required addr=%h wdata=%h be=%b",
                   mem_addr, mem_wdata, mem_be, mon_e.addr, mon_e.wdata, mon_e.be);
        end
      end
    end
  end

  function automatic exp_t exp_of(input logic b, input logic h, input logic [31:0] a,
                                  input logic [31:0] d);
    exp_t e;
    e.addr = {a[31:2], 2'b00};
    if (b) begin
      e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
      case (a[1:0])
        2'd0:    e.be = 4'b0001;
        2'd1:    e.be = 4'b0010;
        2'd2:    e.be = 4'b0100;
        default: e.be = 4'b1000;
      endcase
    end else if (h) begin
      e.wdata = {d[15:0], d[15:0]};
      e.be    = a[1] ? 4'b1100 : 4'b0011;
    end else begin
      e.wdata = d;
      e.be    = 4'hF;
    end
    return e;
  endfunction

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push_store(input logic b, input logic h, input logic [31:0] a,
                            input logic [31:0] d, input logic enq);
    int waited;
    st_valid = 1'b1;
    st_byte  = b;
    st_half  = h;
    st_addr  = a;
    st_data  = d;
    waited   = 0;
    @(negedge clk);
    while (!st_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    checks++;
    if (!st_ready) begin
      errors++;
      $display("FAIL push_timeout: st_ready=%b after %0d cycles, required 1", st_ready, waited);
    end else if (enq) begin
      sb.push_back(exp_of(b, h, a, d));
    end
    @(posedge clk);
    #1;
    st_valid = 1'b0;
  endtask

  // Call at posedge+1; grants long enough to empty a full buffer.
  task automatic drain();
    mem_gnt = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    mem_gnt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_be !== 4'h0 || busy !== 1'b0 || st_ready !== 1'b1 ||
        misalign_exc !== 1'b0 || exc_addr !== '0) begin
      errors++;
      $display("FAIL reset_state: req=%b be=%b busy=%b ready=%b exc=%b exc_addr=%h, required 0 0 0 1 0 0",
               mem_req, mem_be, busy, st_ready, misalign_exc, exc_addr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_byte();
    push_store(1'b1, 1'b0, 32'h1003, 32'hAB, 1'b1);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h1000 || mem_wdata !== 32'hABABABAB ||
        mem_be !== 4'b1000) begin
      errors++;
      $display("FAIL byte_store: req=%b addr=%h wdata=%h be=%b, required 1 00001000 abababab 1000",
               mem_req, mem_addr, mem_wdata, mem_be);
    end
    @(posedge clk);
    #1;
    drain();
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL byte_drain: busy=%b outstanding=%0d, required 0 0", busy, sb.size());
    end
  endtask

  task automatic test_half_word();
    push_store(1'b0, 1'b1, 32'h2002, 32'h1234, 1'b1);
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h2000 || mem_wdata !== 32'h12341234 || mem_be !== 4'b1100) begin
      errors++;
      $display("FAIL half_store: addr=%h wdata=%h be=%b, required 00002000 12341234 1100",
               mem_addr, mem_wdata, mem_be);
    end
    @(posedge clk);
    #1;
    drain();
    push_store(1'b0, 1'b0, 32'h3000, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h3000 || mem_wdata !== 32'hDEADBEEF || mem_be !== 4'hF) begin
      errors++;
      $display("FAIL word_store: addr=%h wdata=%h be=%b, required 00003000 deadbeef 1111",
               mem_addr, mem_wdata, mem_be);
    end
    @(posedge clk);
    #1;
    drain();
    // Byte at offset 1 with other data bits set: only d[7:0] is replicated.
    push_store(1'b1, 1'b1, 32'h2101, 32'hFFFF_FF5A, 1'b1);
    @(negedge clk);
    checks++;
    if (mem_wdata !== 32'h5A5A5A5A || mem_be !== 4'b0010) begin
      errors++;
      $display("FAIL byte_priority: wdata=%h be=%b, required 5a5a5a5a 0010", mem_wdata, mem_be);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_full_backpressure();
    exp_t third;
    mem_gnt = 1'b0;
    push_store(1'b1, 1'b0, 32'h5001, 32'h11, 1'b1);
    push_store(1'b0, 1'b1, 32'h6002, 32'h2222, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (st_ready !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h5000 ||
          mem_wdata !== 32'h11111111 || mem_be !== 4'b0010) begin
        errors++;
        $display("FAIL full_hold[%0d]: ready=%b req=%b addr=%h wdata=%h be=%b, required 0 1 00005000 11111111 0010",
                 i, st_ready, mem_req, mem_addr, mem_wdata, mem_be);
      end
    end
    // Grant once while a third store waits: it must not slip in on the pop cycle.
    @(posedge clk);
    #1;
    mem_gnt  = 1'b1;
    st_valid = 1'b1;
    st_byte  = 1'b0;
    st_half  = 1'b0;
    st_addr  = 32'h7000;
    st_data  = 32'hCAFEF00D;
    third    = exp_of(1'b0, 1'b0, 32'h7000, 32'hCAFEF00D);
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_no_bypass: st_ready=%b during pop, required 0", st_ready);
    end
    @(posedge clk);
    #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b1 || mem_addr !== 32'h6000 || mem_be !== 4'b1100) begin
      errors++;
      $display("FAIL after_pop: ready=%b addr=%h be=%b, required 1 00006000 1100",
               st_ready, mem_addr, mem_be);
    end
    sb.push_back(third);
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    drain();
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL full_drain: busy=%b outstanding=%0d, required 0 0", busy, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int          start;
    logic        b;
    logic        h;
    logic [31:0] a;
    logic [31:0] d;
    start   = n_issued;
    mem_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = (i % 3 == 0);
      h = (i % 3 == 1);
      a = 32'h8000 + 32'(i * 5);
      d = $urandom;
      st_valid = 1'b1;
      st_byte  = b;
      st_half  = h;
      st_addr  = a;
      st_data  = d;
      @(negedge clk);
      checks++;
      if (st_ready !== 1'b1 || (i > 0 && (mem_req !== 1'b1 || busy !== 1'b1))) begin
        errors++;
        $display("FAIL b2b_stream[%0d]: ready=%b req=%b busy=%b, required 1 1 1",
                 i, st_ready, mem_req, busy);
      end
      sb.push_back(exp_of(b, h, a, d));
      @(posedge clk);
      #1;
    end
    st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last_issue: mem_req=%b, required 1", mem_req);
    end
    @(posedge clk);
    #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_issued - start != 6) begin
      errors++;
      $display("FAIL b2b_done: busy=%b issues=%0d, required 0 6", busy, n_issued - start);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_flush();
    mem_gnt = 1'b0;
    push_store(1'b0, 1'b0, 32'h9000, 32'h01020304, 1'b1);
    push_store(1'b1, 1'b0, 32'h9005, 32'h77, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_be !== 4'h0 || busy !== 1'b0 || st_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flush: req=%b be=%b busy=%b ready=%b, required 0 0000 0 1",
               mem_req, mem_be, busy, st_ready);
    end
    @(posedge clk);
    #1;
    mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_issue[%0d]: mem_req=%b, required 0", i, mem_req);
      end
    end
    @(posedge clk);
    #1;
    mem_gnt = 1'b0;
  endtask

  task automatic test_misalign();
`ifdef STORE_MISALIGN_TRAP_EN
    push_store(1'b0, 1'b0, 32'h4002, 32'h55AA55AA, 1'b0);
    @(negedge clk);
    checks++;
    if (misalign_exc !== 1'b1 || exc_addr !== 32'h4002 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL trap_pulse: exc=%b exc_addr=%h req=%b, required 1 00004002 0",
               misalign_exc, exc_addr, mem_req);
    end
    @(negedge clk);
    checks++;
    if (misalign_exc !== 1'b0 || exc_addr !== 32'h4002 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL trap_one_cycle: exc=%b exc_addr=%h req=%b, required 0 00004002 0",
               misalign_exc, exc_addr, mem_req);
    end
    @(posedge clk);
    #1;
    push_store(1'b0, 1'b1, 32'h4006, 32'hBEEF, 1'b1);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_be !== 4'b1100 || misalign_exc !== 1'b0) begin
      errors++;
      $display("FAIL trap_then_aligned: req=%b be=%b exc=%b, required 1 1100 0",
               mem_req, mem_be, misalign_exc);
    end
    @(posedge clk);
    #1;
    drain();
`else
    push_store(1'b0, 1'b0, 32'h4002, 32'h55AA55AA, 1'b1);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h4000 || mem_be !== 4'hF ||
        misalign_exc !== 1'b0 || exc_addr !== '0) begin
      errors++;
      $display("FAIL no_trap_word: req=%b addr=%h be=%b exc=%b exc_addr=%h, required 1 00004000 1111 0 0",
               mem_req, mem_addr, mem_be, misalign_exc, exc_addr);
    end
    @(posedge clk);
    #1;
    drain();
`endif
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL misalign_drain: busy=%b outstanding=%0d, required 0 0", busy, sb.size());
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_byte  = 1'b0;
    st_half  = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    mem_gnt  = 1'b0;
    test_reset();
    test_byte();
    test_half_word();
    test_full_backpressure();
    test_back_to_back();
    test_reset_flush();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
